// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline stage with flush, optional
// 2-entry skid buffer (registered in_ready) and a saturating stall counter.
module pipe_stage_reg #(
    parameter int WIDTH     = 71,
    parameter bit REG_READY = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] main_q, main_nx, skid_q, skid_nx;
    logic             rdy_q;
    logic             in_xfer, out_xfer;

    assign out_valid = state != EMPTY;
    assign in_ready  = REG_READY ? rdy_q : (!out_valid || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign out_data  = main_q;
    assign occupancy = state;

    // With REG_READY=0 the input-only case in ONE cannot occur, so TWO is unreachable.
    always_comb begin
        state_nx = state;
        main_nx  = main_q;
        skid_nx  = skid_q;
        if (flush) begin
            state_nx = EMPTY;
            main_nx  = '0;
            skid_nx  = '0;
        end else begin
            case (state)
                EMPTY: if (in_xfer) begin
                    main_nx  = in_data;
                    state_nx = ONE;
                end
                ONE: if (in_xfer && out_xfer) begin
                    main_nx = in_data;
                end else if (in_xfer) begin
                    skid_nx  = in_data;
                    state_nx = TWO;
                end else if (out_xfer) begin
                    state_nx = EMPTY;
                end
                TWO: if (out_xfer) begin
                    main_nx  = skid_q;
                    state_nx = ONE;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
            rdy_q  <= 1'b1;
        end else begin
            state  <= state_nx;
            main_q <= main_nx;
            skid_q <= skid_nx;
            rdy_q  <= state_nx != TWO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: both buffering modes side by side on shared stimulus,
// checked every cycle against queue-based reference models.
module tb_pipe_stage_reg;
    localparam int W  = 71;
    localparam int CW = 4;
    localparam int SMAX = 15;

    logic clk = 1'b0;
    logic rst_n, flush, in_valid, out_ready;
    logic [W-1:0] in_data;
    logic r1, v1, r0, v0;
    logic [W-1:0] d1, d0;
    logic [1:0] o1, o0;
    logic [CW-1:0] s1, s0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .REG_READY(1'b1), .CNT_W(CW)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r1),
        .in_data(in_data), .out_valid(v1), .out_ready(out_ready), .out_data(d1),
        .occupancy(o1), .stall_cnt(s1));

    pipe_stage_reg #(.WIDTH(W), .REG_READY(1'b0), .CNT_W(CW)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r0),
        .in_data(in_data), .out_valid(v0), .out_ready(out_ready), .out_data(d0),
        .occupancy(o0), .stall_cnt(s0));

    // Reference: each stage is a FIFO of capacity 2 (skid) or 1 (plain).
    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];
    int st1 = 0;
    int st0 = 0;
    bit mi1, mi0, mo1, mo0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q1.delete(); q0.delete(); st1 = 0; st0 = 0;
        end else begin
            mi1 = in_valid && q1.size() < 2;
            mi0 = in_valid && (q0.size() == 0 || out_ready);
            mo1 = q1.size() != 0 && out_ready;
            mo0 = q0.size() != 0 && out_ready;
            if (q1.size() != 0 && !out_ready && st1 < SMAX) st1++;
            if (q0.size() != 0 && !out_ready && st0 < SMAX) st0++;
            if (flush) begin
                q1.delete(); q0.delete();
            end else begin
                if (mo1) void'(q1.pop_front());
                if (mi1) q1.push_back(in_data);
                if (mo0) void'(q0.pop_front());
                if (mi0) q0.push_back(in_data);
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("m1 valid", 128'(v1), 128'(q1.size() != 0));
            chk("m1 ready", 128'(r1), 128'(q1.size() < 2));
            chk("m1 occ", 128'(o1), 128'(q1.size()));
            chk("m1 stall", 128'(s1), 128'(st1));
            if (q1.size() != 0) chk("m1 data", 128'(d1), 128'(q1[0]));
            chk("m0 valid", 128'(v0), 128'(q0.size() != 0));
            chk("m0 ready", 128'(r0), 128'(q0.size() == 0 || out_ready));
            chk("m0 occ", 128'(o0), 128'(q0.size()));
            chk("m0 stall", 128'(s0), 128'(st0));
            if (q0.size() != 0) chk("m0 data", 128'(d0), 128'(q0[0]));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
        in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " v1"}, 128'(v1), 128'(0));
        chk({nm, " r1"}, 128'(r1), 128'(1));
        chk({nm, " o1"}, 128'(o1), 128'(0));
        chk({nm, " d1"}, 128'(d1), 128'(0));
        chk({nm, " s1"}, 128'(s1), 128'(0));
        chk({nm, " v0"}, 128'(v0), 128'(0));
        chk({nm, " r0"}, 128'(r0), 128'(1));
        chk({nm, " d0"}, 128'(d0), 128'(0));
        chk({nm, " s0"}, 128'(s0), 128'(0));
    endtask

    localparam logic [W-1:0] A = W'(72'hA0A0);
    localparam logic [W-1:0] B = W'(72'hB0B0);
    localparam logic [W-1:0] C = W'(72'hC0C0);
    localparam logic [W-1:0] K = W'(72'h1_2345_6789_ABCD_EF01_5);

    initial begin
        rst_n = 1'b0;
        drive(0, '0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_reset_vals("reset");

        // Stall counter: saturates at 15, survives flush.
        drive(1, C, 1, 0); edge_();
        drive(0, '0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            edge_();
            chk("stall1", 128'(s1), 128'((k < SMAX) ? k : SMAX));
            chk("stall0", 128'(s0), 128'((k < SMAX) ? k : SMAX));
        end

        // Flush in TWO with a beat presented.
        drive(1, A, 0, 0); edge_();
        chk("flush pre occ1", 128'(o1), 128'(2));
        drive(1, B, 1, 1); edge_();
        chk("flush v1", 128'(v1), 128'(0));
        chk("flush o1", 128'(o1), 128'(0));
        chk("flush d1", 128'(d1), 128'(0));
        chk("flush s1", 128'(s1), 128'(SMAX));
        chk("flush v0", 128'(v0), 128'(0));
        chk("flush d0", 128'(d0), 128'(0));
        drive(0, '0, 1, 0); edge_();
        chk("flush beat gone1", 128'(v1), 128'(0));
        chk("flush beat gone0", 128'(v0), 128'(0));

        // Streaming 0..7 back to back.
        for (int i = 0; i < 8; i++) begin
            drive(1, W'(i), 1, 0); edge_();
            chk("stream d1", 128'(d1), 128'(i));
            chk("stream d0", 128'(d0), 128'(i));
            chk("stream r1", 128'(r1), 128'(1));
            chk("stream r0", 128'(r0), 128'(1));
        end
        drive(0, '0, 1, 0); edge_();
        chk("drain o1", 128'(o1), 128'(0));

        // Skid and combinational ready.
        drive(1, A, 1, 0); edge_();
        chk("skid A d1", 128'(d1), 128'(A));
        drive(1, B, 0, 0); #1;
        chk("skid r1 still", 128'(r1), 128'(1));
        chk("comb r0 low", 128'(r0), 128'(0));
        edge_();
        chk("skid o1", 128'(o1), 128'(2));
        chk("skid hold d1", 128'(d1), 128'(A));
        drive(0, '0, 0, 0); #1;
        chk("skid r1 low", 128'(r1), 128'(0));
        edge_();
        chk("skid hold2 d1", 128'(d1), 128'(A));
        drive(1, C, 1, 0); #1;
        chk("comb r0 high", 128'(r0), 128'(1));
        edge_();
        chk("skid B d1", 128'(d1), 128'(B));
        chk("skid r1 back", 128'(r1), 128'(1));
        chk("comb C d0", 128'(d0), 128'(C));
        chk("comb C o0", 128'(o0), 128'(1));
        drive(0, '0, 1, 0); edge_();
        chk("skid empty", 128'(o1), 128'(0));

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, W'({$urandom, $urandom, $urandom}),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
            edge_();
        end

        // Asynchronous reset while in TWO.
        drive(1, A, 1, 0); edge_();
        drive(1, B, 0, 0); edge_();
        chk("pre-reset o1", 128'(o1), 128'(2));
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async reset");
        edge_();
        rst_n = 1'b1;
        drive(1, K, 1, 0); #1;
        chk("post-reset not yet", 128'(v1), 128'(0));
        edge_();
        chk("post-reset v1", 128'(v1), 128'(1));
        chk("post-reset d1", 128'(d1), 128'(K));
        chk("post-reset d0", 128'(d0), 128'(K));
        drive(0, '0, 1, 0); edge_();
        edge_();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register for the MIPS pipeline. It replaces the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. The block carries an opaque payload of WIDTH bits under a valid/ready handshake, and adds the following:

- synchronous flush (bubble insertion);
- optional 2-entry skid buffer so that `in_ready` is registered;
- a saturating stall counter for performance monitoring.

## Interface

Parameters:

- `WIDTH`, 71: payload width in bits. The default matches the MEM→WB bundle: MemtoReg, RegWrite, dmReadData[31:0], ALUResult[31:0], Dst[4:0].
- `REG_READY`, 1: selects the buffering mode.
  - 1: 2-entry skid buffer; `in_ready` comes straight from a flop.
  - 0: single register; `in_ready` is combinational from `out_ready`.
- `CNT_W`, 16: width of the stall counter.

Ports:

- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous reset, active-low.
- `flush`, input, 1: synchronous kill of all held entries.
- `in_valid`, input, 1: the upstream stage presents a beat.
- `in_ready`, output, 1: this stage can accept a beat.
- `in_data`, input, WIDTH: upstream payload.
- `out_valid`, output, 1: `out_data` holds a valid beat.
- `out_ready`, input, 1: the downstream stage consumes a beat.
- `out_data`, output, WIDTH: payload of the head entry.
- `occupancy`, output, 2: number of held entries (0..2).
- `stall_cnt`, output, CNT_W: count of cycles with `out_valid && !out_ready`.

## Operation

- Transfers:
  - An input transfer is `in_valid && in_ready` at a rising edge.
  - An output transfer is `out_valid && out_ready` at a rising edge.
- Storage:
  - The `main` register drives `out_data`.
  - The `skid` register exists only when REG_READY=1.
- State machine when REG_READY=1. `occupancy` equals the state encoding.
  - EMPTY (0):
    - `in_ready`=1 and `out_valid`=0.
    - On an input transfer: `main` ← `in_data`, go to ONE.
  - ONE (1):
    - `in_ready`=1 and `out_valid`=1.
    - Input and output transfer together: `main` ← `in_data`, stay in ONE.
    - Input transfer only: `skid` ← `in_data`, go to TWO.
    - Output transfer only: go to EMPTY.
    - Neither: hold.
  - TWO (2):
    - `in_ready`=0 and `out_valid`=1.
    - On an output transfer: `main` ← `skid`, go to ONE.
    - Otherwise hold. No input is accepted in TWO.
- REG_READY=0:
  - Only EMPTY and ONE exist.
  - `in_ready` = `!out_valid || out_ready`, combinational.
  - In ONE, an output transfer together with an input transfer reloads `main` and stays in ONE.
- Flush:
  - Flush has the highest priority. When `flush`=1 at an edge:
    - the state goes to EMPTY;
    - `main` and `skid` are cleared to 0, so a killed MEM/WB beat shows RegWrite=0;
    - a beat presented in the same cycle with `in_ready`=1 counts as consumed and is discarded.
  - `stall_cnt` is not affected by flush.
- Stall counter:
  - Increments by 1 on every edge where `out_valid && !out_ready`.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset.
- Data integrity:
  - The payload is never modified.
  - Beats leave in the order they were accepted; none are dropped or duplicated, except by flush.

## Timing

- Reset (asynchronous assert, synchronous release) sets:
  - state EMPTY and `occupancy`=0;
  - `out_valid`=0;
  - `in_ready`=1;
  - `out_data`=0 and `skid`=0;
  - `stall_cnt`=0.
- Latency: a beat accepted at edge N appears with `out_valid`=1 after edge N.
- Zero-bubble path:
  - Throughput is 1 beat per cycle while `out_ready`=1.
  - Latency stays 1 cycle in both modes.
- `in_ready` in REG_READY=1 mode:
  - It is a flop output, `in_ready` = (state != TWO).
  - A downstream stall in ONE costs one skid slot before backpressure reaches upstream, one cycle later.
- Backpressure stability:
  - While `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` hold stable, except under flush.
- Reset mid-operation:
  - Outputs drop to reset values immediately, with no clock needed.
  - In-flight beats are lost.

## Test plan

- **Reset state.** Assert `rst_n`=0 mid-stream while in TWO. Required response:
  - immediately `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_data`=0, `stall_cnt`=0;
  - the first beat after release (0x1_2345_6789_ABCD_EF01_5) appears one cycle after acceptance.
- **Streaming.** With `out_ready`=1, send 8 back-to-back beats 0..7. Required response:
  - `out_data` shows 0..7 on consecutive cycles, each one cycle after its input;
  - `in_ready` stays 1.
- **Skid (REG_READY=1).** In ONE holding A, drop `out_ready` and present B. Required response:
  - B is accepted and `occupancy`=2;
  - the next cycle `in_ready`=0 and `out_data`=A holds;
  - raise `out_ready`: A, then B, leave on consecutive cycles; `in_ready` returns to 1 after A leaves.
- **Combinational ready (REG_READY=0).** In ONE with `out_ready`=0:
  - `in_ready`=0 in the same cycle;
  - raising `out_ready` gives `in_ready`=1 in that same cycle, and a simultaneous new beat replaces `main` with no bubble.
- **Flush.** In TWO, pulse `flush` with `in_valid`=1. Required response:
  - next cycle `out_valid`=0, `occupancy`=0, `out_data`=0;
  - the presented beat never appears at the output;
  - `stall_cnt` is unchanged.
- **Stall counter.** With CNT_W=4, hold `out_valid`=1 and `out_ready`=0 for 20 cycles. Required response:
  - `stall_cnt` counts 1..15 and then holds at 15;
  - a flush does not clear it.
